// File: rtl/data_mem_resp.sv
// Request/acknowledge data memory: fixed three-cycle IDLE->ACCESS->ACK handshake, registered read data.
// Optional build macro DMEM_CLEAR_EN adds a post-reset CLEAR sweep that zeroes every word.
module data_mem_resp #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              busy,
  output logic              err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

`ifdef DMEM_CLEAR_EN
  typedef enum logic [1:0] {IDLE, ACCESS, ACK, CLEAR} state_t;
  localparam state_t RST_STATE = CLEAR;
  localparam logic [IDX_W-1:0] CLR_LAST = IDX_W'(DEPTH - 1);
  logic [IDX_W-1:0] clr_cnt_reg;
`else
  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
  localparam state_t RST_STATE = IDLE;
`endif

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_reg;
  logic                ack_reg;
  logic                err_reg;
  logic                in_range;
  logic                mem_we;
  logic [IDX_W-1:0]    mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  logic [DATA_W-1:0]   mem [DEPTH];

  assign in_range = ({1'b0, addr_q} < DEPTH_L);
  assign rdata    = rdata_reg;
  assign ack      = ack_reg;
  assign err      = err_reg;
  assign busy     = (state_reg != IDLE);

  always_comb begin
    state_next = state_reg;
    mem_we     = 1'b0;
    mem_waddr  = addr_q[IDX_W-1:0];
    mem_wdata  = wdata_q;
    case (state_reg)
      IDLE:   if (req) state_next = ACCESS;
      ACCESS: begin
        state_next = ACK;
        mem_we     = we_q && in_range;
      end
      ACK:    state_next = IDLE;
`ifdef DMEM_CLEAR_EN
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_reg;
        mem_wdata = '0;
        if (clr_cnt_reg == CLR_LAST) state_next = IDLE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Reset pulls state out of ACCESS asynchronously, which is what aborts a pending write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RST_STATE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      rdata_reg <= '0;
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ack_reg   <= (state_reg == ACCESS);
      err_reg   <= (state_reg == ACCESS) && !in_range;
      if (state_reg == IDLE && req) begin
        addr_q  <= addr;
        we_q    <= we;
        wdata_q <= wdata;
      end
      if (state_reg == ACCESS && !we_q)
        rdata_reg <= in_range ? mem[addr_q[IDX_W-1:0]] : '0;
    end
  end

`ifdef DMEM_CLEAR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      clr_cnt_reg <= '0;
    else if (state_reg == CLEAR)
      clr_cnt_reg <= clr_cnt_reg + 1'b1;
  end
`endif

  // Storage array kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the data word width in bits.
REQ-002 Parameter ADDR_W, default 8, SHALL set the address width in bits.
REQ-003 Parameter DEPTH, default 256, SHALL set the number of words, with DEPTH <= 2**ADDR_W.
REQ-004 Port clk, input, 1 bit, SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 Port rst_n, input, 1 bit, SHALL be the asynchronous active-low reset.
REQ-006 Port req, input, 1 bit, SHALL be the access request from the datapath.
REQ-007 Port we, input, 1 bit, SHALL select the access type: 1 = write, 0 = read.
REQ-008 Port addr, input, ADDR_W bits, SHALL carry the word address from the address-select mux (literal or register B).
REQ-009 Port wdata, input, DATA_W bits, SHALL carry the write data.
REQ-010 Port rdata, output, DATA_W bits, SHALL carry the registered read data.
REQ-011 Port ack, output, 1 bit, SHALL signal access completion as a one-cycle registered pulse.
REQ-012 Port busy, output, 1 bit, SHALL be high whenever the block cannot accept a request.
REQ-013 Port err, output, 1 bit, SHALL flag an out-of-range address and is valid only while ack=1.

Function
REQ-014 The FSM SHALL have states IDLE, ACCESS and ACK, plus CLEAR when REQ-027 applies.
REQ-015 On a rising edge in IDLE with req=1, the block SHALL latch addr, we and wdata into internal registers and enter ACCESS.
REQ-016 While in ACCESS or ACK, the block SHALL ignore changes on req, addr, we and wdata.
REQ-017 In ACCESS with in-range write, the next edge SHALL perform mem[addr_q] <= wdata_q; rdata SHALL hold its value.
REQ-018 In ACCESS with in-range read, the next edge SHALL perform rdata <= mem[addr_q].
REQ-019 ACCESS SHALL always transition to ACK, with ack=1 for exactly one clock period; ACK SHALL always transition to IDLE.
REQ-020 Latency SHALL be fixed: req sampled at edge N gives ack=1 between edges N+1 and N+2, for both reads and writes.
REQ-021 When addr_q >= DEPTH: a write SHALL be dropped, a read SHALL set rdata=0, and err=1 together with ack.
REQ-022 busy SHALL be 1 in every state other than IDLE; req=1 held through ACK SHALL be accepted in the following IDLE cycle as a new request.
REQ-023 Read-after-write to the same address on consecutive transactions SHALL return the newly written data.
REQ-024 rdata SHALL hold the last read value until the next read completes.

Reset
REQ-025 Asserting rst_n=0 SHALL immediately force state=IDLE, ack=0, busy=0, err=0 and rdata=0, regardless of the clock.
REQ-026 A reset asserted before the ACCESS edge SHALL abort the pending write; memory contents are not reset except as defined in REQ-027.

Configuration
REQ-027 With macro DMEM_CLEAR_EN defined, reset SHALL enter CLEAR instead of IDLE, and after rst_n deassertion SHALL behave as follows:
- write 0 to addresses 0..DEPTH-1, one per cycle, using a sweep counter;
- hold busy=1 and ignore req for exactly DEPTH cycles;
- then enter IDLE.
REQ-028 Without DMEM_CLEAR_EN, the CLEAR state and the sweep counter SHALL not exist, reset SHALL go directly to IDLE, and unwritten words are undefined.

Verification
REQ-029 Write then read: write addr=8'h10 wdata=8'hA5, then read 8'h10 -> ack 2 edges after each req sample, rdata=8'hA5, err=0.
REQ-030 Back-to-back: req held high for 3 reads of 8'h00, 8'h01, 8'h02 -> one ack every 3 cycles, busy=1 between acks, each rdata correct.
REQ-031 Out-of-range: DEPTH=128, write 8'h80 then read 8'h80 -> err=1 with each ack, rdata=8'h00, mem[0] unchanged.
REQ-032 Input stability: change addr/wdata during ACCESS -> write lands at the originally latched address with the original data.
REQ-033 Mid-operation reset: pull rst_n low during ACCESS of a write to 8'h20 -> ack=0 immediately, and a later read of 8'h20 returns the previous value.
REQ-034 DMEM_CLEAR_EN defined: release reset -> busy=1 for DEPTH cycles and req ignored, then a read of 8'hFF returns 8'h00.
